// File: rtl/trace_sched_pkg.sv
// Shared definitions for the trace scheduler: FSM state encoding and the
// channel-index width helper used to size event and sweep indices.
package trace_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_CLEAR = 2'd2
    } state_e;

    // A single channel still needs a one-bit index.
    function automatic int ch_idx_width(input int n_ch);
        if (n_ch > 1) begin
            return $clog2(n_ch);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/trace_prescaler.sv
// Free-running prescaler for the trace scheduler: counts 0..p_prescale-1 and
// raises a registered tick for the cycle in which the count sits at its top.
module trace_prescaler #(
    parameter int p_prescale = 8
) (
    input  logic i_clk,
    input  logic i_rst,
    output logic o_tick
);

    localparam int               LP_CW   = (p_prescale > 1) ? $clog2(p_prescale) : 1;
    localparam logic [LP_CW-1:0] LP_LAST = LP_CW'(p_prescale - 1);

    logic [LP_CW-1:0] cnt_q;
    logic [LP_CW-1:0] cnt_d;
    logic             tick_q;
    logic             tick_d;

    // Wrap the count at the top and flag the cycle that will hold the top value.
    always_comb begin
        if (cnt_q == LP_LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + LP_CW'(1);
        end
        if (cnt_d == LP_LAST) begin
            tick_d = 1'b1;
        end else begin
            tick_d = 1'b0;
        end
    end

    // Counter and tick registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign o_tick = tick_q;

endmodule

// File: rtl/trace_scheduler.sv
// Eligibility-trace scheduler: events set a channel trace to max, periodic
// sweeps decay every trace by one, i_clear zeroes them. Optional macro
// TRACE_OVERRUN_EN builds the sticky tick-overrun detector behind o_overrun.
module trace_scheduler
    import trace_sched_pkg::*;
#(
    parameter int p_width    = 8,
    parameter int p_channels = 4,
    parameter int p_prescale = 8
) (
    input  logic                                 i_clk,
    input  logic                                 i_rst,
    input  logic                                 i_event_valid,
    input  logic [ch_idx_width(p_channels)-1:0]  i_event_ch,
    output logic                                 o_event_ready,
    input  logic                                 i_clear,
    output logic [p_channels*p_width-1:0]        o_trace,
    output logic                                 o_busy,
    output logic                                 o_sweep_done,
    output logic                                 o_overrun
);

    localparam int                 LP_CW   = ch_idx_width(p_channels);
    localparam logic [LP_CW-1:0]   LP_LAST = LP_CW'(p_channels - 1);
    localparam logic [p_width-1:0] LP_MAX  = '1;

    state_e             state_q;
    state_e             state_d;
    logic [LP_CW-1:0]   idx_q;
    logic [LP_CW-1:0]   idx_d;
    logic               pending_q;
    logic               pending_d;
    logic [p_width-1:0] trace_q [p_channels];
    logic [p_width-1:0] trace_d [p_channels];

    logic tick_s;
    logic ready_s;
    logic accept_s;
    logic busy_s;
    logic sweep_done_s;

    trace_prescaler #(
        .p_prescale (p_prescale)
    ) u_prescaler (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .o_tick (tick_s)
    );

    // FSM state, walk index and pending-tick register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            pending_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            pending_q <= pending_d;
        end
    end

    // Next state: clear beats tick; a tick outside an IDLE launch is parked in pending.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        pending_d = pending_q;
        case (state_q)
            ST_IDLE: begin
                if (i_clear) begin
                    state_d   = ST_CLEAR;
                    idx_d     = '0;
                    pending_d = pending_q | tick_s;
                end else if (tick_s || pending_q) begin
                    state_d   = ST_SWEEP;
                    idx_d     = '0;
                    pending_d = 1'b0;
                end else begin
                    state_d   = ST_IDLE;
                end
            end
            ST_SWEEP: begin
                pending_d = pending_q | tick_s;
                if (i_clear) begin
                    state_d = ST_CLEAR;
                    idx_d   = '0;
                end else if (idx_q == LP_LAST) begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                end else begin
                    idx_d   = idx_q + LP_CW'(1);
                end
            end
            ST_CLEAR: begin
                pending_d = pending_q | tick_s;
                if (idx_q == LP_LAST) begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                end else begin
                    idx_d   = idx_q + LP_CW'(1);
                end
            end
            default: begin
                state_d   = ST_IDLE;
                idx_d     = '0;
                pending_d = 1'b0;
            end
        endcase
    end

    // Status outputs are forced low for as long as reset is held.
    always_comb begin
        ready_s      = 1'b0;
        busy_s       = 1'b0;
        sweep_done_s = 1'b0;
        if (i_rst) begin
            ready_s      = 1'b0;
            busy_s       = 1'b0;
            sweep_done_s = 1'b0;
        end else begin
            ready_s      = (state_q != ST_CLEAR);
            busy_s       = (state_q != ST_IDLE);
            sweep_done_s = (state_q == ST_SWEEP) && (idx_q == LP_LAST) && !i_clear;
        end
        accept_s = i_event_valid && ready_s;
    end

    // Per-channel update: an accepted event overrides the sweep decrement.
    always_comb begin
        trace_d = trace_q;
        for (int c = 0; c < p_channels; c++) begin
            if (accept_s && (int'(i_event_ch) == c)) begin
                trace_d[c] = LP_MAX;
            end else if ((state_q == ST_SWEEP) && (int'(idx_q) == c)) begin
                if (trace_q[c] == '0) begin
                    trace_d[c] = trace_q[c];
                end else begin
                    trace_d[c] = trace_q[c] - p_width'(1);
                end
            end else if ((state_q == ST_CLEAR) && (int'(idx_q) == c)) begin
                trace_d[c] = '0;
            end else begin
                trace_d[c] = trace_q[c];
            end
        end
    end

    // Trace array.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int c = 0; c < p_channels; c++) begin
                trace_q[c] <= '0;
            end
        end else begin
            trace_q <= trace_d;
        end
    end

    // Flatten the trace array onto the output bus.
    always_comb begin
        o_trace = '0;
        for (int c = 0; c < p_channels; c++) begin
            if (i_rst) begin
                o_trace[c*p_width +: p_width] = '0;
            end else begin
                o_trace[c*p_width +: p_width] = trace_q[c];
            end
        end
    end

    assign o_event_ready = ready_s;
    assign o_busy        = busy_s;
    assign o_sweep_done  = sweep_done_s;

`ifdef TRACE_OVERRUN_EN
    logic overrun_q;
    logic overrun_d;

    // A tick landing on an already-pending tick is lost; remember that until reset.
    always_comb begin
        if (tick_s && pending_q) begin
            overrun_d = 1'b1;
        end else begin
            overrun_d = overrun_q;
        end
    end

    // Sticky overrun flag.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            overrun_q <= 1'b0;
        end else begin
            overrun_q <= overrun_d;
        end
    end

    assign o_overrun = overrun_q & ~i_rst;
`else
    assign o_overrun = 1'b0;
`endif

endmodule

// File: tb/tb_trace_scheduler.sv
// Directed self-checking bench for trace_scheduler (8-bit, 4 channels) with a
// second instance at prescale 2 for back-to-back pending-tick sweeps.
module tb_trace_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        ev_valid;
    logic [1:0]  ev_ch;
    logic        clr;
    logic        ev_ready;
    logic [31:0] trace;
    logic        busy;
    logic        done;
    logic        ovr;

    logic        ev_valid2;
    logic [1:0]  ev_ch2;
    logic        clr2;
    logic        ev_ready2;
    logic [31:0] trace2;
    logic        busy2;
    logic        done2;
    logic        ovr2;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] exp_q [$];
    logic [7:0]  model [4];

`ifdef TRACE_OVERRUN_EN
    localparam logic [31:0] EXP_OVR2 = 32'd1;
`else
    localparam logic [31:0] EXP_OVR2 = 32'd0;
`endif

    always #5 clk = ~clk;

    trace_scheduler #(.p_width(8), .p_channels(4), .p_prescale(8)) dut (
        .i_clk(clk), .i_rst(rst), .i_event_valid(ev_valid), .i_event_ch(ev_ch),
        .o_event_ready(ev_ready), .i_clear(clr), .o_trace(trace), .o_busy(busy),
        .o_sweep_done(done), .o_overrun(ovr)
    );

    trace_scheduler #(.p_width(8), .p_channels(4), .p_prescale(2)) dut2 (
        .i_clk(clk), .i_rst(rst), .i_event_valid(ev_valid2), .i_event_ch(ev_ch2),
        .o_event_ready(ev_ready2), .i_clear(clr2), .o_trace(trace2), .o_busy(busy2),
        .o_sweep_done(done2), .o_overrun(ovr2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic sb_check(input string tag);
        logic [31:0] e;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $error("FAIL %s: observed=empty-queue expected=queued-entry", tag);
        end else begin
            e = exp_q.pop_front();
            chk(tag, trace, e);
        end
    endtask

    function automatic logic [31:0] model_vec();
        return {model[3], model[2], model[1], model[0]};
    endfunction

    // Expected traces after one sweep; an event at sweep cycle ev_at on e_ch.
    task automatic run_sweep(input int exp_gap, input int ev_at, input logic [1:0] e_ch);
        int   n;
        int   len;
        int   done_at;
        int   done_cnt;
        logic hit;
        for (int c = 0; c < 4; c++) begin
            hit = (ev_at >= 0) && (c == int'(e_ch));
            if (hit && ev_at < c) model[c] = 8'hFF;
            if (model[c] != 8'h00) model[c] = model[c] - 8'h01;
            if (hit && ev_at >= c) model[c] = 8'hFF;
        end
        exp_q.push_back(model_vec());

        n = 0;
        while (busy !== 1'b1 && n < 64) begin
            @(negedge clk);
            n++;
        end
        if (exp_gap >= 0) chk("sweep_gap", n, exp_gap);
        len      = 0;
        done_at  = -1;
        done_cnt = 0;
        while (busy === 1'b1 && len < 64) begin
            if (len == ev_at) begin
                ev_valid = 1'b1;
                ev_ch    = e_ch;
                #1;
                chk("ready_in_sweep", ev_ready, 1);
            end else begin
                ev_valid = 1'b0;
            end
            if (done === 1'b1) begin
                done_at = len;
                done_cnt++;
            end
            @(negedge clk);
            len++;
        end
        ev_valid = 1'b0;
        chk("sweep_len", len, 4);
        chk("sweep_done_at", done_at, 3);
        chk("sweep_done_cnt", done_cnt, 1);
        sb_check("trace_after_sweep");
    endtask

    initial begin
        int   n;
        int   done_at;
        logic done_seen;

        rst = 1'b1; ev_valid = 1'b0; ev_ch = 2'd0; clr = 1'b0;
        ev_valid2 = 1'b0; ev_ch2 = 2'd0; clr2 = 1'b0;
        for (int c = 0; c < 4; c++) model[c] = 8'h00;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_ready", ev_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_overrun", ovr, 0);
        chk("rst_trace", trace, 0);

        // Event on ch2 straight out of reset
        rst = 1'b0; ev_valid = 1'b1; ev_ch = 2'd2;
        model[2] = 8'hFF;
        exp_q.push_back(model_vec());
        #1;
        chk("ready_idle", ev_ready, 1);
        @(negedge clk);
        ev_valid = 1'b0;
        sb_check("event_ch2");

        // Three decays: FE, FD, FC
        run_sweep(7, -1, 2'd0);
        run_sweep(4, -1, 2'd0);
        run_sweep(4, -1, 2'd0);
        chk("ch2_after_3", trace[23:16], 8'hFC);

        // Event on ch1 in the same cycle the sweep decrements ch1
        run_sweep(4, 1, 2'd1);
        chk("ev_beats_dec", trace[15:8], 8'hFF);

        // Decay both traces to zero and one sweep beyond (no wrap)
        for (int s = 0; s < 256; s++) run_sweep(4, -1, 2'd0);
        chk("no_wrap", trace, 0);

        // Clear on the last sweep cycle with all traces held at FF by events
        exp_q.push_back(32'hFFFF_FFFF);
        n = 0;
        while (busy !== 1'b1 && n < 64) begin
            @(negedge clk);
            n++;
        end
        chk("clr_gap", n, 4);
        for (int k = 0; k < 4; k++) begin
            ev_valid = 1'b1;
            ev_ch    = 2'(k);
            clr      = (k == 3);
            #1;
            chk("clr_ready_sweep", ev_ready, 1);
            if (k == 3) chk("clr_no_done_last", done, 0);
            @(negedge clk);
        end
        ev_valid = 1'b0;
        clr      = 1'b0;
        sb_check("all_ff_at_clear");
        n = 0;
        done_seen = 1'b0;
        while (ev_ready !== 1'b1 && n < 64) begin
            if (done === 1'b1) done_seen = 1'b1;
            @(negedge clk);
            n++;
        end
        chk("clr_ready_low", n, 4);
        chk("clr_no_done", done_seen, 0);
        chk("clr_zero", trace, 0);
        chk("clr_back_idle", busy, 0);
        @(negedge clk);
        chk("pending_sweep", busy, 1);
        n = 0;
        while (busy === 1'b1 && n < 64) begin
            @(negedge clk);
            n++;
        end
        chk("pending_sweep_len", n, 4);
        chk("pending_sweep_trace", trace, 0);

        // Reset in the middle of a sweep
        ev_valid = 1'b1; ev_ch = 2'd0;
        @(negedge clk);
        ev_valid = 1'b0;
        chk("reload_ch0", trace[7:0], 8'hFF);
        chk("p2_overrun_pre", ovr2, EXP_OVR2);
        n = 0;
        while (busy !== 1'b1 && n < 64) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_ready", ev_ready, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_trace", trace, 0);
        chk("midrst_ovr2", ovr2, 0);
        @(negedge clk);
        chk("rst2_trace", trace, 0);
        chk("rst2_busy", busy, 0);
        rst = 1'b0;
        #1;
        chk("post_rst_trace", trace, 0);
        chk("post_rst_ready", ev_ready, 1);
        n = 0;
        while (busy !== 1'b1 && n < 64) begin
            @(negedge clk);
            n++;
        end
        chk("prescale_restart", n, 8);

        // Prescale 2: every sweep after the first is launched from a pending tick
        n = 0;
        while (busy2 === 1'b1 && n < 64) begin
            @(negedge clk);
            n++;
        end
        for (int r = 0; r < 3; r++) begin
            n = 0;
            while (busy2 !== 1'b1 && n < 64) begin
                @(negedge clk);
                n++;
            end
            chk("p2_gap", n, 1);
            n = 0;
            done_at = -1;
            while (busy2 === 1'b1 && n < 64) begin
                if (done2 === 1'b1) done_at = n;
                @(negedge clk);
                n++;
            end
            chk("p2_len", n, 4);
            chk("p2_done_at", done_at, 3);
        end
        chk("p2_overrun", ovr2, EXP_OVR2);
        chk("p8_no_overrun", ovr, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/trace_scheduler.md
TRACE_SCHEDULER -- requirements
Module: trace_scheduler

Interface
REQ-001 SHALL have parameter p_width, default 8, trace width in bits.
REQ-002 SHALL have parameter p_channels, default 4, number of trace channels (>=2).
REQ-003 SHALL have parameter p_prescale, default 8, clock cycles between decay ticks (>=2).
REQ-004 SHALL have port i_clk  input  1  sole clock, all logic on rising edge.
REQ-005 SHALL have port i_rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port i_event_valid  input  1  event request.
REQ-007 SHALL have port i_event_ch  input  $clog2(p_channels)  target channel of event.
REQ-008 SHALL have port o_event_ready  output  1  event accepted when valid&ready.
REQ-009 SHALL have port i_clear  input  1  request to zero all traces.
REQ-010 SHALL have port o_trace  output  p_channels*p_width  flattened traces, channel c at bits [c*p_width +: p_width].
REQ-011 SHALL have port o_busy  output  1  high in SWEEP or CLEAR.
REQ-012 SHALL have port o_sweep_done  output  1  one-cycle pulse on final sweep cycle.
REQ-013 SHALL have port o_overrun  output  1  sticky tick-overrun flag (see Configuration).

Function
REQ-014 SHALL hold one p_width trace register per channel; max value is all ones.
REQ-015 SHALL run a free prescaler counting 0..p_prescale-1, raising tick when count = p_prescale-1, in every state.
REQ-016 SHALL implement states IDLE, SWEEP, CLEAR.
REQ-017 IDLE->SWEEP when tick or pending-tick set; sweep index starts 0; pending-tick cleared on entry.
REQ-018 In SWEEP, channel index i SHALL be decremented by 1 at cycle i (saturating at 0); sweep lasts exactly p_channels cycles, then IDLE, o_sweep_done high on the last cycle.
REQ-019 A tick occurring outside IDLE SHALL set a single pending-tick bit; further ticks while pending are dropped.
REQ-020 o_event_ready SHALL be 1 in IDLE and SWEEP, 0 in CLEAR and while i_rst is high.
REQ-021 Accepted event SHALL set the target trace to max on that edge; visible on o_trace the next cycle.
REQ-022 Event and decrement on the same channel in the same cycle: event wins (trace = max).
REQ-023 Accepted event with i_event_ch >= p_channels SHALL be consumed and ignored.
REQ-024 i_clear in IDLE or SWEEP SHALL enter CLEAR next cycle (aborting any sweep, no o_sweep_done); CLEAR zeroes channel i at cycle i for p_channels cycles, then IDLE.
REQ-025 i_clear during CLEAR SHALL be ignored; i_clear and tick together: clear wins, tick becomes pending.
REQ-026 An event presented in the cycle i_clear is sampled in IDLE/SWEEP SHALL still be accepted.

Reset
REQ-027 While i_rst high: all traces 0, state IDLE, prescaler 0, pending-tick 0, o_busy 0, o_sweep_done 0, o_overrun 0, o_event_ready 0.
REQ-028 Reset mid-SWEEP or mid-CLEAR SHALL abort immediately with no partial pulse.

Configuration
REQ-029 Macro TRACE_OVERRUN_EN defined: o_overrun SHALL set when a tick arrives while pending-tick already set, cleared only by reset.
REQ-030 Macro TRACE_OVERRUN_EN undefined: o_overrun SHALL be constant 0 and no detection logic built; all other behaviour identical.

Structure
REQ-031 Package trace_sched_pkg SHALL hold the state encoding (IDLE, SWEEP, CLEAR) and the channel-index width function.
REQ-032 Prescaler SHALL be sub-module trace_prescaler (parameter p_prescale; outputs tick); FSM, trace array, arbitration stay in trace_scheduler.

Verification (p_width=8, p_channels=4, p_prescale=8)
REQ-033 Event ch2 after reset -> o_trace ch2 = 0xFF next cycle; after first sweep 0xFE, after 3 sweeps 0xFC; others 0.
REQ-034 Event ch1 on the cycle sweep index = 1 -> ch1 = 0xFF afterwards, not 0xFE.
REQ-035 Trace at 0x01, two sweeps -> 0x00 then stays 0x00 (no wrap).
REQ-036 i_clear mid-sweep with all traces 0xFF -> ready low 4 cycles, all traces 0, no o_sweep_done, pending tick triggers sweep on return to IDLE.
REQ-037 p_prescale=2, p_channels=4 -> pending-tick used each sweep; with TRACE_OVERRUN_EN o_overrun sets, without stays 0.
REQ-038 i_rst asserted mid-sweep -> next cycle all outputs at reset values, prescaler restarts from 0.
